// File: rtl/alu_pkg.sv
// Shared definitions for the ALU sequencer, its wait counter and the ALU top level.
package alu_pkg;

  localparam int unsigned STATE_W = 3;
  localparam int unsigned OP_W    = 4;
  localparam int unsigned DATA_W  = 8;
  localparam int unsigned CNT_W   = 4;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE  = 3'd0,
    ST_GOT_A = 3'd1,
    ST_GOT_B = 3'd2,
    ST_EXEC  = 3'd3,
    ST_WAIT  = 3'd4,
    ST_DONE  = 3'd5
  } state_t;

endpackage

// File: rtl/seq_wait_counter.sv
// Down-counter timing the WAIT phase: load, decrement, zero flag.
module seq_wait_counter
  import alu_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  input  logic             i_dec,
  output logic             o_zero
);

  logic [CNT_W-1:0] r_count;

  // Count register; load has priority, decrement saturates at zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_dec && (r_count != '0)) begin
      r_count <= r_count - CNT_W'(1);
    end
  end

  assign o_zero = (r_count == '0);

endmodule

// File: rtl/alu_sequencer.sv
// Steps operands and op code from switches into an external ALU, strobes it,
// waits EXEC_WAIT cycles and captures the result.
module alu_sequencer
  import alu_pkg::*;
#(
  parameter int unsigned EXEC_WAIT = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [DATA_W-1:0]  data,
  input  logic [OP_W-1:0]    op_sel,
  input  logic               step,
  input  logic               chain,
  input  logic               clear,
  input  logic [DATA_W-1:0]  alu_y,
  output logic [DATA_W-1:0]  alu_a,
  output logic [DATA_W-1:0]  alu_b,
  output logic [OP_W-1:0]    alu_op,
  output logic               alu_perform,
  output logic [DATA_W-1:0]  result,
  output logic [STATE_W-1:0] phase,
  output logic               busy,
  output logic               done
);

  // The counter holds the number of WAIT cycles still to go after the
  // current one, so the capture happens in the WAIT cycle where it reads zero.
  localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'(EXEC_WAIT - 1);

  state_t             r_state;
  state_t             w_next_state;
  logic [DATA_W-1:0]  r_alu_a;
  logic [DATA_W-1:0]  r_alu_b;
  logic [OP_W-1:0]    r_alu_op;
  logic [DATA_W-1:0]  r_result;

  logic w_ld_a_data;
  logic w_ld_a_res;
  logic w_ld_b;
  logic w_ld_op;
  logic w_capture;
  logic w_cnt_load;
  logic w_cnt_dec;
  logic w_cnt_zero;

  seq_wait_counter u_wait_counter (
    .clk        (clk),
    .rst        (reset),
    .i_load     (w_cnt_load),
    .i_load_val (WAIT_LOAD),
    .i_dec      (w_cnt_dec),
    .o_zero     (w_cnt_zero)
  );

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state and register-load decode; clear overrides every transition.
  always_comb begin
    w_next_state = r_state;
    w_ld_a_data  = 1'b0;
    w_ld_a_res   = 1'b0;
    w_ld_b       = 1'b0;
    w_ld_op      = 1'b0;
    w_capture    = 1'b0;
    w_cnt_load   = 1'b0;
    w_cnt_dec    = 1'b0;
    if (clear) begin
      w_next_state = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (step) begin
            w_ld_a_data  = 1'b1;
            w_next_state = ST_GOT_A;
          end
        end
        ST_GOT_A: begin
          if (step) begin
            w_ld_b       = 1'b1;
            w_next_state = ST_GOT_B;
          end
        end
        ST_GOT_B: begin
          if (step) begin
            w_ld_op      = 1'b1;
            w_next_state = ST_EXEC;
          end
        end
        ST_EXEC: begin
          w_cnt_load   = 1'b1;
          w_next_state = ST_WAIT;
        end
        ST_WAIT: begin
          if (w_cnt_zero) begin
            w_capture    = 1'b1;
            w_next_state = ST_DONE;
          end else begin
            w_cnt_dec = 1'b1;
          end
        end
        ST_DONE: begin
          if (step) begin
            if (chain) begin
              w_ld_a_res   = 1'b1;
              w_next_state = ST_GOT_A;
            end else begin
              w_next_state = ST_IDLE;
            end
          end
        end
        default: w_next_state = ST_IDLE;
      endcase
    end
  end

  // Operand, op and result registers; they move only on the decoded loads.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_alu_a  <= '0;
      r_alu_b  <= '0;
      r_alu_op <= '0;
      r_result <= '0;
    end else begin
      if (w_ld_a_data) begin
        r_alu_a <= data;
      end else if (w_ld_a_res) begin
        r_alu_a <= r_result;
      end
      if (w_ld_b) begin
        r_alu_b <= data;
      end
      if (w_ld_op) begin
        r_alu_op <= op_sel;
      end
      if (w_capture) begin
        r_result <= alu_y;
      end
    end
  end

  assign alu_a       = r_alu_a;
  assign alu_b       = r_alu_b;
  assign alu_op      = r_alu_op;
  assign result      = r_result;
  assign phase       = r_state;
  assign alu_perform = (r_state == ST_EXEC);
  assign busy        = (r_state == ST_EXEC) || (r_state == ST_WAIT);
  assign done        = (r_state == ST_DONE);

endmodule

// File: doc/alu_sequencer.md
ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 The block SHALL use one clock; reset is asynchronous and active-high.
REQ-002 Parameter: EXEC_WAIT, 2, number of cycles after alu_perform before alu_y is captured (legal range 1..15).
REQ-003 Port: clk  input  1  system clock, all state on rising edge.
REQ-004 Port: reset  input  1  asynchronous active-high reset.
REQ-005 Port: data  input  8  operand value from switches.
REQ-006 Port: op_sel  input  4  operation code from switches.
REQ-007 Port: step  input  1  single-cycle, clk-synchronous advance request.
REQ-008 Port: chain  input  1  at DONE, selects result as next operand A.
REQ-009 Port: clear  input  1  single-cycle synchronous abort.
REQ-010 Port: alu_y  input  8  ALU result.
REQ-011 Port: alu_a, alu_b  output  8 each  registered operands to the ALU and LEDs.
REQ-012 Port: alu_op  output  4  registered op code to the ALU.
REQ-013 Port: alu_perform  output  1  one-cycle execute strobe.
REQ-014 Port: result  output  8  last captured alu_y.
REQ-015 Port: phase  output  3  current state encoding.
REQ-016 Port: busy  output  1  high in EXEC and WAIT.
REQ-017 Port: done  output  1  high in DONE.

Function
REQ-018 States and encodings: IDLE=0, GOT_A=1, GOT_B=2, EXEC=3, WAIT=4, DONE=5. Codes 6-7 SHALL return to IDLE on the next edge.
REQ-019 IDLE + step: alu_a<=data, go GOT_A.
REQ-020 GOT_A + step: alu_b<=data, go GOT_B.
REQ-021 GOT_B + step: alu_op<=op_sel, go EXEC.
REQ-022 EXEC: lasts exactly one cycle with alu_perform=1, then go WAIT. alu_perform SHALL be 0 in all other states.
REQ-023 WAIT: lasts exactly EXEC_WAIT cycles, counted by a 4-bit down-counter. On the last WAIT edge, result<=alu_y and go DONE.
REQ-024 Latency: for a step sampled at edge k in GOT_B, EXEC occupies cycle k+1, WAIT occupies cycles k+2..k+EXEC_WAIT+1, and DONE/done start at cycle k+EXEC_WAIT+2.
REQ-025 DONE + step with chain=1: alu_a<=result, alu_b unchanged, go GOT_A.
REQ-026 DONE + step with chain=0: go IDLE, operands unchanged.
REQ-027 step in EXEC or WAIT SHALL be ignored (not queued).
REQ-028 clear SHALL force IDLE on the next edge from any state. It leaves alu_a, alu_b, alu_op and result unchanged, and aborts any pending capture.
REQ-029 If clear and step occur in the same cycle, clear SHALL win.
REQ-030 Operand, op and result registers SHALL change only at the transitions named above. data and op_sel SHALL be don't-care otherwise.
REQ-031 phase, busy and done SHALL be decoded from the state register only (no combinational path from inputs).

Reset
REQ-032 On reset assertion, outputs SHALL immediately become state=IDLE, alu_a=alu_b=0, alu_op=0, result=0, alu_perform=0, busy=0, done=0, and the WAIT counter SHALL be 0.
REQ-033 Reset mid-operation (EXEC/WAIT) SHALL cancel the capture. result SHALL remain 0.
REQ-034 First active edge after reset deassertion: the block SHALL respond to step normally.

Structure
REQ-035 State encodings, the state width (3) and the op width (4) SHALL live in the shared alu_pkg header, also used by the ALU and top level.
REQ-036 The WAIT down-counter SHALL be the single sub-module seq_wait_counter (load, decrement, zero flag).
REQ-037 Target size: 120-250 lines RTL.

Verification
REQ-038 Basic op: with EXEC_WAIT=2, step with data=0x12, step with data=0x34, step with op_sel=0x1, model alu_y=0x46. Required: alu_perform pulses one cycle, done rises 4 cycles after the third step, result=0x46, busy=1 for exactly 3 cycles.
REQ-039 Chain: from DONE with result=0x46, chain=1, step, then data=0x02, step, step. Required: alu_a=0x46, alu_b=0x02, new EXEC occurs.
REQ-040 Ignored step: a step in each WAIT cycle. Required: timing identical to REQ-038, no extra alu_perform.
REQ-041 Clear priority: clear and step together in GOT_B. Required: next phase=0, alu_op unchanged, no alu_perform.
REQ-042 Reset mid-WAIT: assert reset in the second WAIT cycle. Required: immediately phase=0 and result=0, and done never asserts.
REQ-043 Boundary: with EXEC_WAIT=1, done rises 3 cycles after the third step. With EXEC_WAIT=15, done rises after 17 cycles.
